// File: rtl/data_memory.sv
// 256 x 8 data memory with a fixed, parameterised access latency.
// The initiator is stalled through busywait; an illegal read+write request raises a one-cycle err.
module data_memory #(
    parameter int unsigned LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       op_wr_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] readdata_q;
    logic       err_q;
    logic [7:0] mem_q [256];

    logic req_ok;
    logic req_bad;
    logic start;
    logic access;

    assign req_ok  = read ^ write;
    assign req_bad = read & write;
    assign start   = (state_q == StIdle) && req_ok;
    assign access  = (state_q == StBusy) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_ok) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_wr_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            readdata_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_q == StIdle) && req_bad;
            // Request fields are captured once so churn during BUSY cannot leak in.
            if (start) begin
                op_wr_q <= write;
                addr_q  <= address;
                wdata_q <= writedata;
            end
            if (access && !op_wr_q) begin
                readdata_q <= mem_q[addr_q];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (access && op_wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    // Combinational so the initiator stalls in the same cycle it raises a request.
    assign busywait = !reset && (start || (state_q == StBusy));
    assign readdata = readdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: scoreboard of expected read data plus a shadow memory.
// A LATENCY=4 instance carries the main tests; LATENCY=1 and LATENCY=15 instances cover the sweep.
module tb_data_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic       read, write;
    logic [7:0] address, writedata;
    logic [7:0] readdata;
    logic       busywait, err;

    logic       s_read [2];
    logic [7:0] s_rdata [2];
    logic       s_busy [2];
    logic       s_err [2];

    logic [7:0] shadow [256];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    data_memory #(.LATENCY(4)) u_dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait), .err(err)
    );

    data_memory #(.LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .read(s_read[0]), .write(1'b0), .address(8'h42),
        .writedata(8'h00), .readdata(s_rdata[0]), .busywait(s_busy[0]), .err(s_err[0])
    );

    data_memory #(.LATENCY(15)) u_lat15 (
        .clk(clk), .reset(reset), .read(s_read[1]), .write(1'b0), .address(8'h42),
        .writedata(8'h00), .readdata(s_rdata[1]), .busywait(s_busy[1]), .err(s_err[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Counts sampled cycles with busywait high, starting at the current (already settled) sample.
    task automatic wait_done(output int n);
        n = 0;
        while (busywait && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 40) check("timeout", 32'(n), 32'd0);
    endtask

    // One access on the main instance; churn scrambles address/data while BUSY.
    task automatic access(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                          input bit churn);
        int n;
        @(negedge clk);
        address = a; writedata = d; read = !is_wr; write = is_wr;
        if (!is_wr) exp_q.push_back(shadow[a]);
        #1;
        check("stall_same_cycle", 32'(busywait), 32'd1);
        n = 0;
        while (busywait && n < 40) begin
            n++;
            @(negedge clk);
            if (churn) begin
                address = a + 8'd1; writedata = 8'hFF;
            end
            #1;
        end
        check("busy_cycles", 32'(n - 1), 32'd4);
        read = 1'b0; write = 1'b0;
        if (is_wr) shadow[a] = d;
        else if (exp_q.size() > 0) check("readdata", 32'(readdata), 32'(exp_q.pop_front()));
    endtask

    task automatic sweep_read(input int idx, input int lat);
        int n;
        @(negedge clk);
        s_read[idx] = 1'b1;
        exp_q.push_back(8'h00);
        n = 0;
        @(negedge clk);
        while (s_busy[idx] && n < 40) begin
            n++;
            @(negedge clk);
        end
        s_read[idx] = 1'b0;
        check($sformatf("sweep_edges_lat%0d", lat), 32'(n), 32'(lat));
        if (exp_q.size() > 0)
            check($sformatf("sweep_rdata_lat%0d", lat), 32'(s_rdata[idx]), 32'(exp_q.pop_front()));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] rd_before;
        read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
        s_read[0] = 1'b0; s_read[1] = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        @(negedge clk);
        read = 1'b1;
        #1;
        check("reset_busywait", 32'(busywait), 32'd0);
        check("reset_readdata", 32'(readdata), 32'h00);
        check("reset_err", 32'(err), 32'd0);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Write then read
        access(1'b1, 8'h05, 8'hA3, 1'b0);
        access(1'b0, 8'h05, 8'h00, 1'b0);

        // Latency sweep
        sweep_read(0, 1);
        sweep_read(1, 15);

        // Illegal request leaves memory and readdata alone
        access(1'b1, 8'h10, 8'h3C, 1'b0);
        rd_before = readdata;
        @(negedge clk);
        address = 8'h10; writedata = 8'hEE; read = 1'b1; write = 1'b1;
        #1;
        check("illegal_busywait", 32'(busywait), 32'd0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #1;
        check("illegal_err_pulse", 32'(err), 32'd1);
        check("illegal_busywait_after", 32'(busywait), 32'd0);
        @(negedge clk);
        #1;
        check("illegal_err_low", 32'(err), 32'd0);
        check("illegal_readdata", 32'(readdata), 32'(rd_before));
        access(1'b0, 8'h10, 8'h00, 1'b0);

        // Input churn during BUSY
        access(1'b1, 8'h20, 8'h55, 1'b1);
        access(1'b0, 8'h20, 8'h00, 1'b0);
        access(1'b0, 8'h21, 8'h00, 1'b0);

        // Reset mid-write aborts the store
        @(negedge clk);
        address = 8'h30; writedata = 8'h77; write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_busywait", 32'(busywait), 32'd0);
        write = 1'b0;
        do_reset();
        access(1'b0, 8'h30, 8'h00, 1'b0);
        access(1'b0, 8'h05, 8'h00, 1'b0);

        // Back-to-back reads at address extremes, read held across DONE
        access(1'b1, 8'hFF, 8'hC3, 1'b0);
        access(1'b1, 8'h00, 8'h5A, 1'b0);
        @(negedge clk);
        address = 8'hFF; read = 1'b1;
        exp_q.push_back(shadow[8'hFF]);
        #1;
        wait_done(n);
        check("b2b_cycles_first", 32'(n), 32'd5);
        if (exp_q.size() > 0) check("b2b_rdata_ff", 32'(readdata), 32'(exp_q.pop_front()));
        address = 8'h00;
        exp_q.push_back(shadow[8'h00]);
        @(negedge clk);
        #1;
        check("b2b_restart", 32'(busywait), 32'd1);
        wait_done(n);
        check("b2b_cycles_second", 32'(n), 32'd5);
        if (exp_q.size() > 0) check("b2b_rdata_00", 32'(readdata), 32'(exp_q.pop_front()));
        read = 1'b0;

        check("sweep_err_lat1", 32'(s_err[0]), 32'd0);
        check("sweep_err_lat15", 32'(s_err[1]), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
